instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 18 +
 rtl/instr_fetch_pc_reg.sv | 44 ++++
 rtl/instr_fetch.sv | 133 +++++++++++++
 tb/tb_instr_fetch.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_fetch_pkg : shared CPU defines (word width, NOP, fetch FSM states)  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package instr_fetch_pkg;

   localparam int c_WORD_W = 16;
   localparam logic [c_WORD_W-1:0] c_NOP_INSTR = 16'h0800;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_PRESENT = 2'd2
   } fetch_state_t;

endpackage : instr_fetch_pkg
`default_nettype wire

// File: rtl/instr_fetch_pc_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_reg : program counter with branch-load / post-fetch increment mux     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pc_reg
   import instr_fetch_pkg::*;
#(
   parameter logic [c_WORD_W-1:0] RESET_PC = 16'h0000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_load_en,
   input  logic [c_WORD_W-1:0] i_load_val,
   input  logic                i_inc_en,
   input  logic [c_WORD_W-1:0] i_inc_base,
   output logic [c_WORD_W-1:0] o_pc
);

   logic [c_WORD_W-1:0] r_pc;
   logic [c_WORD_W-1:0] w_pc_next;

   // A redirect always wins over the sequential increment; the add wraps at 2^16.
   always_comb begin
      w_pc_next = r_pc;
      if (i_load_en) begin
         w_pc_next = i_load_val;
      end else if (i_inc_en) begin
         w_pc_next = i_inc_base + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc <= RESET_PC;
      end else begin
         r_pc <= w_pc_next;
      end
   end

   assign o_pc = r_pc;

endmodule : pc_reg
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_fetch : IF stage - memory request FSM, branch squash, IF/ID output  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [c_WORD_W-1:0] RESET_PC  = 16'h0000,
   parameter logic [c_WORD_W-1:0] NOP_INSTR = c_NOP_INSTR
) (
   input  logic                ifi_clk,
   input  logic                ifi_rst,
   input  logic                ifi_stall,
   input  logic                ifi_br_taken,
   input  logic [c_WORD_W-1:0] ifi_br_target,
   output logic                ifo_mem_req,
   output logic [c_WORD_W-1:0] ifo_mem_addr,
   input  logic                ifi_mem_ack,
   input  logic [c_WORD_W-1:0] ifi_mem_data,
   output logic [c_WORD_W-1:0] ifo_addr,
   output logic [c_WORD_W-1:0] ifo_instr,
   output logic                ifo_valid
);

   fetch_state_t        r_state;
   fetch_state_t        w_state_next;
   logic [c_WORD_W-1:0] r_fetch_addr;
   logic [c_WORD_W-1:0] w_fetch_addr_next;
   logic                r_discard;
   logic                w_discard_next;
   logic                w_valid_next;
   logic [c_WORD_W-1:0] w_addr_next;
   logic [c_WORD_W-1:0] w_instr_next;
   logic                w_pc_load;
   logic                w_pc_inc;
   logic [c_WORD_W-1:0] w_pc;

   pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk        (ifi_clk),
      .rst        (ifi_rst),
      .i_load_en  (w_pc_load),
      .i_load_val (ifi_br_target),
      .i_inc_en   (w_pc_inc),
      .i_inc_base (r_fetch_addr),
      .o_pc       (w_pc)
   );

   always_comb begin
      w_state_next      = r_state;
      w_fetch_addr_next = r_fetch_addr;
      w_discard_next    = r_discard;
      w_valid_next      = ifo_valid;
      w_addr_next       = ifo_addr;
      w_instr_next      = ifo_instr;
      w_pc_load         = 1'b0;
      w_pc_inc          = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_state_next      = S_WAIT;
            w_pc_load         = ifi_br_taken;
            w_fetch_addr_next = ifi_br_taken ? ifi_br_target : w_pc;
         end
         S_WAIT: begin
            if (ifi_mem_ack) begin
               if (r_discard || ifi_br_taken) begin
                  // Stale return: drop it and re-issue at the redirected address.
                  w_discard_next    = 1'b0;
                  w_pc_load         = ifi_br_taken;
                  w_fetch_addr_next = ifi_br_taken ? ifi_br_target : w_pc;
               end else begin
                  w_addr_next  = r_fetch_addr;
                  w_instr_next = ifi_mem_data;
                  w_valid_next = 1'b1;
                  w_pc_inc     = 1'b1;
                  w_state_next = S_PRESENT;
               end
            end else if (ifi_br_taken) begin
               // Request address must stay put until memory answers.
               w_pc_load      = 1'b1;
               w_discard_next = 1'b1;
            end
         end
         S_PRESENT: begin
            if (ifi_br_taken) begin
               w_valid_next      = 1'b0;
               w_instr_next      = NOP_INSTR;
               w_pc_load         = 1'b1;
               w_fetch_addr_next = ifi_br_target;
               w_state_next      = S_WAIT;
            end else if (!ifi_stall) begin
               w_valid_next      = 1'b0;
               w_fetch_addr_next = w_pc;
               w_state_next      = S_WAIT;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge ifi_clk or posedge ifi_rst) begin
      if (ifi_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge ifi_clk or posedge ifi_rst) begin
      if (ifi_rst) begin
         r_fetch_addr <= RESET_PC;
         r_discard    <= 1'b0;
         ifo_valid    <= 1'b0;
         ifo_addr     <= 16'h0000;
         ifo_instr    <= NOP_INSTR;
      end else begin
         r_fetch_addr <= w_fetch_addr_next;
         r_discard    <= w_discard_next;
         ifo_valid    <= w_valid_next;
         ifo_addr     <= w_addr_next;
         ifo_instr    <= w_instr_next;
      end
   end

   assign ifo_mem_req  = (r_state == S_WAIT);
   assign ifo_mem_addr = r_fetch_addr;

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_instr_fetch : randomized fetch/stall/branch traffic with scoreboard    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_instr_fetch;

   localparam logic [15:0] RESET_PC_TB = 16'hFFFF;
   localparam logic [15:0] NOP_WORD    = 16'h0800;

   logic        ifi_clk       = 1'b0;
   logic        ifi_rst       = 1'b1;
   logic        ifi_stall     = 1'b0;
   logic        ifi_br_taken  = 1'b0;
   logic [15:0] ifi_br_target = 16'h0000;
   logic        ifi_mem_ack   = 1'b0;
   logic [15:0] ifi_mem_data  = 16'h0000;
   logic        ifo_mem_req;
   logic [15:0] ifo_mem_addr;
   logic [15:0] ifo_addr;
   logic [15:0] ifo_instr;
   logic        ifo_valid;

   int          n_total   = 0;
   int          n_pass    = 0;
   int          n_present = 0;
   logic [15:0] exp_q[$];
   logic [15:0] exp_next  = 16'h0000;
   bit          busy      = 1'b0;
   int          wait_cnt  = 0;
   logic [15:0] req_addr  = 16'h0000;

   instr_fetch #(
      .RESET_PC (RESET_PC_TB)
   ) dut (
      .ifi_clk       (ifi_clk),
      .ifi_rst       (ifi_rst),
      .ifi_stall     (ifi_stall),
      .ifi_br_taken  (ifi_br_taken),
      .ifi_br_target (ifi_br_target),
      .ifo_mem_req   (ifo_mem_req),
      .ifo_mem_addr  (ifo_mem_addr),
      .ifi_mem_ack   (ifi_mem_ack),
      .ifi_mem_data  (ifi_mem_data),
      .ifo_addr      (ifo_addr),
      .ifo_instr     (ifo_instr),
      .ifo_valid     (ifo_valid)
   );

   always #5 ifi_clk = ~ifi_clk;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'hC3A5;
   endfunction

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   // One negedge worth of stimulus: memory responder, hazards, and the
   // architectural model of which address must be presented next.
   task automatic step(input bit rand_en);
      bit fresh;
      fresh = 1'b0;
      ifi_mem_ack = 1'b0;
      if (ifo_mem_req) begin
         if (!busy) begin
            busy     = 1'b1;
            fresh    = 1'b1;
            req_addr = ifo_mem_addr;
            wait_cnt = $urandom_range(0, 3);
         end
         if (wait_cnt == 0) begin
            if (!fresh) chk("mem_addr_stable", ifo_mem_addr, req_addr);
            ifi_mem_ack  = 1'b1;
            ifi_mem_data = mem_word(ifo_mem_addr);
            busy         = 1'b0;
         end else begin
            wait_cnt--;
         end
      end else begin
         busy = 1'b0;
      end
      if (rand_en) begin
         ifi_stall     = ($urandom_range(0, 99) < 35);
         ifi_br_taken  = ($urandom_range(0, 99) < 6);
         ifi_br_target = 16'($urandom);
      end else begin
         ifi_stall    = 1'b0;
         ifi_br_taken = 1'b0;
      end
      if (ifi_br_taken) begin
         exp_q.delete();
         exp_next = ifi_br_target;
         exp_q.push_back(exp_next);
      end else if (ifo_valid && !ifi_stall) begin
         exp_next = exp_next + 16'd1;
         exp_q.push_back(exp_next);
      end
   endtask

   initial begin : monitor
      logic        prev_valid;
      logic [15:0] prev_addr;
      logic [15:0] prev_instr;
      logic [15:0] want;
      bit          after_rst;
      int          idle_cnt;
      prev_valid = 1'b0;
      prev_addr  = 16'h0000;
      prev_instr = 16'h0000;
      after_rst  = 1'b1;
      idle_cnt   = 0;
      forever begin
         @(posedge ifi_clk or posedge ifi_rst);
         #1;
         if (ifi_rst) begin
            chk("rst_valid", {15'd0, ifo_valid}, 16'd0);
            chk("rst_addr", ifo_addr, 16'h0000);
            chk("rst_instr", ifo_instr, NOP_WORD);
            chk("rst_mem_req", {15'd0, ifo_mem_req}, 16'd0);
            prev_valid = 1'b0;
            after_rst  = 1'b1;
            idle_cnt   = 0;
         end else begin
            if (prev_valid) begin
               if (ifi_br_taken) begin
                  chk("squash_valid", {15'd0, ifo_valid}, 16'd0);
                  chk("squash_instr", ifo_instr, NOP_WORD);
                  chk("squash_req", {15'd0, ifo_mem_req}, 16'd1);
                  chk("squash_req_addr", ifo_mem_addr, ifi_br_target);
               end else if (ifi_stall) begin
                  chk("stall_valid", {15'd0, ifo_valid}, 16'd1);
                  chk("stall_addr", ifo_addr, prev_addr);
                  chk("stall_instr", ifo_instr, prev_instr);
                  chk("stall_no_req", {15'd0, ifo_mem_req}, 16'd0);
               end else begin
                  want = prev_addr + 16'd1;
                  chk("consume_valid", {15'd0, ifo_valid}, 16'd0);
                  chk("next_req", {15'd0, ifo_mem_req}, 16'd1);
                  chk("next_req_addr", ifo_mem_addr, want);
               end
            end
            if (ifo_valid && !prev_valid) begin
               n_present++;
               if (exp_q.size() == 0) begin
                  n_total++;
                  $display("FAIL present_unexpected: got addr %h expected no instruction", ifo_addr);
               end else begin
                  want = exp_q.pop_front();
                  chk("present_addr", ifo_addr, want);
                  chk("present_instr", ifo_instr, mem_word(want));
               end
            end
            if (after_rst && ifo_mem_req) begin
               chk("first_req_addr", ifo_mem_addr, RESET_PC_TB);
               after_rst = 1'b0;
            end
            idle_cnt = ifo_valid ? 0 : idle_cnt + 1;
            if (idle_cnt > 200) begin
               n_total++;
               $display("FAIL watchdog: got %0d cycles without valid, required at most 200", idle_cnt);
               idle_cnt = 0;
            end
            prev_valid = ifo_valid;
            prev_addr  = ifo_addr;
            prev_instr = ifo_instr;
         end
      end
   end

   initial begin : driver
      bit found;
      repeat (3) @(negedge ifi_clk);
      ifi_rst  = 1'b0;
      exp_q.delete();
      exp_next = RESET_PC_TB;
      exp_q.push_back(exp_next);
      repeat (3) begin
         @(negedge ifi_clk);
         step(1'b0);
      end
      repeat (3000) begin
         @(negedge ifi_clk);
         step(1'b1);
      end

      // Reset while a request is outstanding, with a stale ack right after release.
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge ifi_clk);
         if (ifo_mem_req) found = 1'b1;
         else step(1'b0);
      end
      if (!found) begin
         n_total++;
         $display("FAIL find_req: got no request within 50 cycles, required one");
      end
      ifi_rst      = 1'b1;
      ifi_mem_ack  = 1'b0;
      ifi_stall    = 1'b0;
      ifi_br_taken = 1'b0;
      busy         = 1'b0;
      repeat (2) @(negedge ifi_clk);
      ifi_rst      = 1'b0;
      ifi_mem_ack  = 1'b1;
      ifi_mem_data = 16'hDEAD;
      exp_q.delete();
      exp_next = RESET_PC_TB;
      exp_q.push_back(exp_next);
      repeat (3) begin
         @(negedge ifi_clk);
         step(1'b0);
      end
      repeat (500) begin
         @(negedge ifi_clk);
         step(1'b1);
      end
      repeat (20) begin
         @(negedge ifi_clk);
         step(1'b0);
      end
      chk("progress", {15'd0, (n_present >= 100)}, 16'd1);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_instr_fetch
`default_nettype wire
